// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with row synchronisation,
// press/release debounce, single-pulse key reporting and no auto-repeat.
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key,
  output logic       key_valid
);

  localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_DONE   = DW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state;
  logic [3:0]    row_meta;
  logic [3:0]    row_s;
  logic [1:0]    col_idx;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] stab_cnt;
  logic [3:0]    cand_key;
  logic [3:0]    cand_rows;
  logic [2:0]    low_count;
  logic [1:0]    low_row;

  // Two-flop synchroniser for the asynchronous row inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_meta <= '1;
      row_s    <= '1;
    end else begin
      row_meta <= row_in;
      row_s    <= row_meta;
    end
  end

  // Count the low rows and locate the (last) low one
  always_comb begin
    low_count = '0;
    low_row   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!row_s[i]) begin
        low_count = low_count + 3'd1;
        low_row   = 2'(i);
      end
    end
  end

  // Scan / debounce / hold / release sequencing with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SCAN;
      col_idx   <= '0;
      col_out   <= 4'b1110;
      scan_cnt  <= '0;
      stab_cnt  <= '0;
      cand_key  <= '0;
      cand_rows <= '1;
      key       <= '0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (scan_cnt != SCAN_LAST) begin
            scan_cnt <= scan_cnt + 1'b1;
          end else if (low_count == 3'd1) begin
            cand_key  <= {low_row, col_idx};
            cand_rows <= row_s;
            stab_cnt  <= DW'(1);
            state     <= DEBOUNCE;
          end else begin
            col_idx  <= col_idx + 2'd1;
            col_out  <= {col_out[2:0], col_out[3]};
            scan_cnt <= '0;
          end
        end
        DEBOUNCE: begin
          // Once the stable count is reached the key is committed on the
          // following edge regardless of that edge's sample.
          if (stab_cnt == DB_DONE) begin
            key       <= cand_key;
            key_valid <= 1'b1;
            stab_cnt  <= '0;
            state     <= HELD;
          end else if (row_s == cand_rows) begin
            stab_cnt <= stab_cnt + 1'b1;
          end else begin
            col_idx  <= col_idx + 2'd1;
            col_out  <= {col_out[2:0], col_out[3]};
            scan_cnt <= '0;
            stab_cnt <= '0;
            state    <= SCAN;
          end
        end
        HELD: begin
          if (row_s == 4'b1111) begin
            stab_cnt <= DW'(1);
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          if (stab_cnt == DB_DONE) begin
            col_idx  <= col_idx + 2'd1;
            col_out  <= {col_out[2:0], col_out[3]};
            scan_cnt <= '0;
            stab_cnt <= '0;
            state    <= SCAN;
          end else if (row_s == 4'b1111) begin
            stab_cnt <= stab_cnt + 1'b1;
          end else begin
            stab_cnt <= '0;
            state    <= HELD;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_CYCLES, default 4, sets the clock cycles each column is driven before its rows are evaluated (minimum 3).
REQ-002 Parameter DEBOUNCE_CYCLES, default 8, sets the consecutive stable samples required to accept a press or release (minimum 2).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 row_in  input  4  keypad rows, active-low (pulled high externally), asynchronous to clk.
REQ-006 col_out  output  4  column drive, active-low, exactly one bit low at all times.
REQ-007 key  output  4  code of the last accepted key, {row index[1:0], column index[1:0]}, giving 4'h0..4'hF.
REQ-008 key_valid  output  1  one-cycle pulse, high in the cycle key first presents a newly accepted code.

Function
REQ-009 row_in SHALL pass through a 2-flop synchronizer (reset value 4'b1111); all decisions use the synchronized value row_s.
REQ-010 FSM states SHALL be SCAN, DEBOUNCE, HELD and RELEASE.
REQ-011 SCAN: hold the current column low for SCAN_CYCLES cycles and evaluate row_s in the last of these cycles.
REQ-012 SCAN evaluation, no row low: advance column 0->1->2->3->0 (col_out 1110->1101->1011->0111->1110) and restart the settle count.
REQ-013 SCAN evaluation, two or more rows low: treat as invalid, advance column, no capture.
REQ-014 SCAN evaluation, exactly one row low: capture candidate {row,col} and the row pattern, keep the column, go to DEBOUNCE with the stable count set to 1.
REQ-015 DEBOUNCE: each cycle row_s equals the captured pattern, increment the count; on any mismatch, return to SCAN on the next column with no output.
REQ-016 When the count reaches DEBOUNCE_CYCLES, on the next edge: key <= candidate, key_valid <= 1 for exactly one cycle, state <= HELD.
REQ-017 HELD: keep the column and emit no further key_valid while any row is low (no auto-repeat); when row_s = 4'b1111, go to RELEASE with the count set to 1.
REQ-018 RELEASE: increment the count while row_s = 4'b1111; any low row returns to HELD without a pulse; at DEBOUNCE_CYCLES, go to SCAN on the next column.
REQ-019 key SHALL hold its value until the next accepted press; key_valid SHALL never be high in two consecutive cycles.
REQ-020 Counters SHALL saturate rather than wrap and SHALL be sized from the parameters via $clog2.
REQ-021 Latency: key_valid SHALL rise exactly DEBOUNCE_CYCLES+1 cycles after the SCAN evaluation cycle that captured the key.
REQ-022 A second key pressed while one is HELD SHALL be ignored until full release completes.

Reset
REQ-023 reset_n low SHALL immediately force state SCAN, column 0 (col_out=4'b1110), key=4'h0, key_valid=0, all counters 0, synchronizer 4'b1111, regardless of the current state.
REQ-024 After reset_n deasserts, the first SCAN evaluation SHALL occur SCAN_CYCLES cycles later.
REQ-025 Reset in DEBOUNCE or HELD SHALL discard the candidate; no key_valid SHALL result from that press.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-026 Reset, no keys -> col_out=1110, key=0, key_valid=0; col_out steps 1110,1101,1011,0111,1110 every 4 cycles.
REQ-027 Row 2 held low while column 1 is driven, stable 100 cycles -> exactly one key_valid with key=4'h9, 9 cycles after evaluation; col_out frozen at 1101 while held.
REQ-028 Row 0 bouncing (low 3, high 2, low 3 cycles) on column 3, then stable -> no pulse during bounce; exactly one pulse with key=4'h3 after stable acceptance.
REQ-029 Rows 1 and 2 both low on column 0 -> no key_valid; col_out keeps rotating.
REQ-030 Release bounce (high 4, low 2, high 20 cycles) after accepted 4'h9 -> no second pulse; scanning resumes at column 2 (col_out=1011).
REQ-031 reset_n pulsed low at DEBOUNCE count 5 -> outputs at reset values immediately; with the key released after reset, no key_valid is ever produced.
